// File: rtl/xnor_serial_cmp.sv
// xnor_serial_cmp
//   Sequential bitwise XNOR comparator. Operands are latched on start and
//   processed STEP bits per clock, LSB slice first. The block produces the
//   XNOR vector, a count of matching bits and an all-equal flag. In
//   early-exit mode it stops after the first slice that has a mismatch.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a comparison (sampled only in IDLE)
//   mode       0 = full compare, 1 = early exit (latched with start)
//   a, b       WIDTH-bit operands (latched with start)
//   busy       high while in RUN
//   done       one-cycle pulse, results valid
//   eq         1 iff all WIDTH bits matched
//   match_cnt  number of matching bit positions processed
//   y          registered a XNOR b, filled slice by slice from the LSB
module xnor_serial_cmp #(
    parameter  int WIDTH = 16,
    parameter  int STEP  = 4,
    localparam int NSL   = WIDTH / STEP,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic [CW-1:0]    match_cnt,
    output logic [WIDTH-1:0] y
);

    // Slice index width; at least one bit so NSL=1 still elaborates.
    localparam int SIW = (NSL > 1) ? $clog2(NSL) : 1;

    generate
        if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_param
            $error("xnor_serial_cmp: STEP must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [SIW-1:0]   r_k;

    logic [WIDTH-1:0] w_xnor;
    int               w_base;
    logic [STEP-1:0]  w_slice;
    logic [CW-1:0]    w_pop;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_miss;

    assign w_xnor    = ~(r_a ^ r_b);
    assign w_base    = int'(r_k) * STEP;
    assign w_slice   = w_xnor[w_base +: STEP];
    assign w_cnt_nxt = match_cnt + w_pop;
    assign w_last    = (r_k == SIW'(NSL - 1));
    assign w_miss    = ~&w_slice;

    // Popcount of the current slice.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < STEP; i++) begin
            w_pop = w_pop + CW'(w_slice[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_mode    <= 1'b0;
            r_k       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            eq        <= 1'b0;
            match_cnt <= '0;
            y         <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Without start, results of the last operation are held.
                    if (start) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_mode    <= mode;
                        r_k       <= '0;
                        y         <= '0;
                        match_cnt <= '0;
                        eq        <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    y[w_base +: STEP] <= w_slice;
                    match_cnt         <= w_cnt_nxt;
                    r_k               <= r_k + SIW'(1);
                    // Early exit leaves the remaining y slices at zero, so
                    // the count can never reach WIDTH and eq stays 0.
                    if (w_last || (r_mode && w_miss)) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        eq      <= (w_cnt_nxt == CW'(WIDTH));
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_serial_cmp.sv
// Self-checking bench for xnor_serial_cmp: table vectors and hand-written
// sequences on the default 16/4 instance via a scoreboard, plus a short
// random sweep on 8/8 and 12/3 instances against a reference model.
module tb_xnor_serial_cmp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: XNOR slice by slice from the LSB, optional early exit.
    task automatic model(input logic [15:0] ma, input logic [15:0] mb, input int w, input int st,
                         input logic md, output logic [15:0] my, output int mc,
                         output logic me, output int ml);
        logic zero_seen;
        my = '0; mc = 0; ml = 0;
        for (int s = 0; s < w / st; s++) begin
            zero_seen = 1'b0;
            ml = s + 1;
            for (int i = s * st; i < (s + 1) * st; i++) begin
                my[i] = ~(ma[i] ^ mb[i]);
                if (my[i]) mc++;
                else zero_seen = 1'b1;
            end
            if (md && zero_seen) break;
        end
        me = (mc == w);
    endtask

    // ---------------- main 16/4 instance ----------------
    logic        start = 1'b0, mode = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, eq;
    logic [4:0]  match_cnt;
    logic [15:0] y;

    xnor_serial_cmp #(.WIDTH(16), .STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .eq(eq), .match_cnt(match_cnt), .y(y)
    );

    typedef struct {
        logic [15:0] y;
        logic [4:0]  cnt;
        logic        eq;
        int          lat;
        int          e0;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Every done pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("y",       32'(y),         32'(mon_e.y));
                chk("cnt",     32'(match_cnt), 32'(mon_e.cnt));
                chk("eq",      32'(eq),        32'(mon_e.eq));
                chk("latency", 32'(cyc),       32'(mon_e.e0 + mon_e.lat));
                chk("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    task automatic push(input logic [15:0] ey, input int ec, input logic ee, input int el, input int e0);
        exp_t e;
        e.y = ey; e.cnt = 5'(ec); e.eq = ee; e.lat = el; e.e0 = e0;
        sb.push_back(e);
    endtask

    // Entered and left at #1 after a posedge.
    task automatic wait_drain();
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) break;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tm,
                          input logic [15:0] ey, input int ec, input logic ee, input int el);
        a = ta; b = tb_; mode = tm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        push(ey, ec, ee, el, cyc);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_drain();
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        mode;
        logic [15:0] y;
        int          cnt;
        logic        eq;
        int          lat;
    } vec_t;

    vec_t vt[8];

    // ---------------- sweep instances ----------------
    logic        s8_start = 1'b0, s8_mode = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        s8_busy, s8_done, s8_eq;
    logic [3:0]  s8_cnt;
    logic [7:0]  s8_y;

    xnor_serial_cmp #(.WIDTH(8), .STEP(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .a(s8_a), .b(s8_b),
        .busy(s8_busy), .done(s8_done), .eq(s8_eq), .match_cnt(s8_cnt), .y(s8_y)
    );

    logic        s12_start = 1'b0, s12_mode = 1'b0;
    logic [11:0] s12_a = '0, s12_b = '0;
    logic        s12_busy, s12_done, s12_eq;
    logic [3:0]  s12_cnt;
    logic [11:0] s12_y;

    xnor_serial_cmp #(.WIDTH(12), .STEP(3)) dut12 (
        .clk(clk), .rst(rst), .start(s12_start), .mode(s12_mode), .a(s12_a), .b(s12_b),
        .busy(s12_busy), .done(s12_done), .eq(s12_eq), .match_cnt(s12_cnt), .y(s12_y)
    );

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_);
        logic [15:0] my; int mc; logic me; int ml; int lat;
        model({8'h0, ta}, {8'h0, tb_}, 8, 8, 1'b0, my, mc, me, ml);
        s8_a = ta; s8_b = tb_; s8_start = 1'b1;
        @(posedge clk); #1;
        s8_start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (s8_done) break;
        end
        chk("w8_latency", 32'(lat),    32'(ml));
        chk("w8_y",       32'(s8_y),   32'(my[7:0]));
        chk("w8_cnt",     32'(s8_cnt), 32'(mc));
        chk("w8_eq",      32'(s8_eq),  32'(me));
        @(posedge clk); #1;
    endtask

    task automatic run12(input logic [11:0] ta, input logic [11:0] tb_);
        logic [15:0] my; int mc; logic me; int ml; int lat;
        model({4'h0, ta}, {4'h0, tb_}, 12, 3, 1'b0, my, mc, me, ml);
        s12_a = ta; s12_b = tb_; s12_start = 1'b1;
        @(posedge clk); #1;
        s12_start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (s12_done) break;
        end
        chk("w12_latency", 32'(lat),     32'(ml));
        chk("w12_y",       32'(s12_y),   32'(my[11:0]));
        chk("w12_cnt",     32'(s12_cnt), 32'(mc));
        chk("w12_eq",      32'(s12_eq),  32'(me));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] ry, ra, rb; int rc, rl; logic re, rm; int c0;

        vt[0] = '{16'hA5A5, 16'hA5A5, 1'b0, 16'hFFFF, 16, 1'b1, 4};
        vt[1] = '{16'h00FF, 16'h0F0F, 1'b0, 16'hF00F,  8, 1'b0, 4};
        vt[2] = '{16'h0001, 16'h0000, 1'b1, 16'h000E,  3, 1'b0, 1};
        vt[3] = '{16'h0001, 16'h0000, 1'b0, 16'hFFFE, 15, 1'b0, 4};
        vt[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000,  0, 1'b0, 1};
        vt[5] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 16, 1'b1, 4};
        vt[6] = '{16'h0000, 16'hF000, 1'b1, 16'h0FFF, 12, 1'b0, 4};
        vt[7] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000,  0, 1'b0, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_done", 32'(done),      32'd0);
        chk("rst_eq",   32'(eq),        32'd0);
        chk("rst_cnt",  32'(match_cnt), 32'd0);
        chk("rst_y",    32'(y),         32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 8; i++)
            run_op(vt[i].a, vt[i].b, vt[i].mode, vt[i].y, vt[i].cnt, vt[i].eq, vt[i].lat);

        // Results held in IDLE with start low
        repeat (3) @(posedge clk);
        #1;
        chk("hold_y",   32'(y),         32'(vt[7].y));
        chk("hold_cnt", 32'(match_cnt), 32'd0);
        chk("hold_busy", 32'(busy),     32'd0);

        // Start held high through RUN and DONE with different operands:
        // ignored until the IDLE cycle after DONE, which accepts it.
        a = 16'h00FF; b = 16'h0F0F; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        push(16'hF00F, 8, 1'b0, 4, c0);
        a = 16'hA5A5; b = 16'hA5A5; mode = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        start = 1'b0;
        push(16'hFFFF, 16, 1'b1, 4, cyc);
        chk("restart_edge", 32'(cyc - c0), 32'd6);
        wait_drain();

        // Reset two edges into RUN aborts without a done pulse
        a = 16'h1111; b = 16'h2222; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(busy),      32'd0);
        chk("abort_done", 32'(done),      32'd0);
        chk("abort_eq",   32'(eq),        32'd0);
        chk("abort_cnt",  32'(match_cnt), 32'd0);
        chk("abort_y",    32'(y),         32'd0);
        repeat (6) @(posedge clk);
        #1;
        run_op(16'h0F0F, 16'h0F0F, 1'b0, 16'hFFFF, 16, 1'b1, 4);

        // Random operands on the main instance against the model
        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = (i % 3 == 0) ? ra : (ra ^ 16'(1 << $urandom_range(15, 0)));
            if (i % 4 == 1) rb = 16'($urandom);
            rm = 1'(i % 2);
            model(ra, rb, 16, 4, rm, ry, rc, re, rl);
            run_op(ra, rb, rm, ry, rc, re, rl);
        end

        // Parameter sweep
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom);
            rb = (i == 0) ? ra : 16'($urandom);
            run8(ra[7:0], rb[7:0]);
            run12(ra[11:0], rb[11:0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
